// File: rtl/bus_pkg.sv
// Shared types and constants for the bus_wait responder.
//   state_e    : responder FSM states (StPend only reachable with posted writes)
//   di_sel_e   : registered DI source select (slow read register or internal RAM)
//   FastTopDefault : default top address of the internal-RAM window
//   is_fast()  : window decode helper
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StPend = 2'd2
  } state_e;

  typedef enum logic {
    DiSlow = 1'b0,
    DiRam  = 1'b1
  } di_sel_e;

  // Zero page plus stack.
  localparam logic [15:0] FastTopDefault = 16'h01FF;

  function automatic logic is_fast(input logic [15:0] addr, input logic [15:0] top);
    return addr <= top;
  endfunction

endpackage

// File: rtl/zp_ram.sv
// Single-port synchronous RAM, 2**AW x 8, for the zero-page/stack window.
// Ports:
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata at addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; only updated by a read, so it holds otherwise
// Contents are not reset.
module zp_ram #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_wait.sv
// Memory-bus responder for a 65C02 core. Accesses at or below FAST_TOP hit an
// internal synchronous RAM with no wait states; everything else is forwarded to
// an external req/ack port while RDY is held low.
// Optional feature macro: BUS_WAIT_POSTED_WRITE_EN -- slow writes are posted into
// a one-entry buffer (RDY stays high) and drained in the background; a slow access
// arriving while the buffer drains waits in StPend.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   AB, DO, WE          : CPU address, write data, write enable
//   DI, RDY             : read data to CPU, registered ready (1 = CPU advances)
//   mem_req, mem_we     : external request (held until ack), external write
//   mem_addr, mem_wdata : external address / write data, stable while mem_req
//   mem_ack, mem_rdata  : single-cycle completion strobe, read data valid with it
module bus_wait
  import bus_pkg::*;
#(
  parameter logic [15:0] FAST_TOP = FastTopDefault,
  parameter int unsigned FAST_AW  = 9  // 2**FAST_AW must exceed FAST_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  state_e      state_q, state_d;
  di_sel_e     sel_q, sel_d;
  logic        rdy_q, rdy_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  slow_q, slow_d;
  logic [7:0]  ram_rdata;

  logic accept;
  logic fast;
  logic slow_accept;
  logic ram_en;

`ifdef BUS_WAIT_POSTED_WRITE_EN
  logic        pend_valid_q, pend_valid_d;
  logic        pend_we_q, pend_we_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_wdata_q, pend_wdata_d;
`endif

  // The core only advances while RDY is high, so RDY doubles as the accept qualifier.
  assign accept      = rdy_q;
  assign fast        = is_fast(AB, FAST_TOP);
  assign slow_accept = accept & ~fast;
  // Addresses above FAST_TOP never enable the RAM, so aliasing of the
  // truncated address is harmless.
  assign ram_en      = accept & fast & ~reset;

  zp_ram #(
    .AW(FAST_AW)
  ) u_zp_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (WE),
    .addr  (AB[FAST_AW-1:0]),
    .wdata (DO),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rdy_d       = rdy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    slow_d      = slow_q;
`ifdef BUS_WAIT_POSTED_WRITE_EN
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
`endif

    if (accept && fast && !WE) begin
      sel_d = DiRam;
    end

    unique case (state_q)
      StIdle: begin
        if (slow_accept) begin
          state_d     = StReq;
          mem_req_d   = 1'b1;
          mem_we_d    = WE;
          mem_addr_d  = AB;
          mem_wdata_d = DO;
`ifdef BUS_WAIT_POSTED_WRITE_EN
          rdy_d       = WE;  // posted write: core keeps running
`else
          rdy_d       = 1'b0;
`endif
        end
      end

      StReq: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            slow_d = mem_rdata;
            sel_d  = DiSlow;
          end
`ifdef BUS_WAIT_POSTED_WRITE_EN
          if (pend_valid_q || slow_accept) begin
            // Next access waits one cycle so mem_req drops between transactions.
            state_d = StPend;
            rdy_d   = 1'b0;
            if (slow_accept) begin
              pend_valid_d = 1'b1;
              pend_we_d    = WE;
              pend_addr_d  = AB;
              pend_wdata_d = DO;
            end
          end else begin
            state_d = StIdle;
            rdy_d   = 1'b1;
          end
`else
          state_d = StIdle;
          rdy_d   = 1'b1;
`endif
        end
`ifdef BUS_WAIT_POSTED_WRITE_EN
        else if (slow_accept) begin
          // Buffer still draining: park the new access and stall the core.
          pend_valid_d = 1'b1;
          pend_we_d    = WE;
          pend_addr_d  = AB;
          pend_wdata_d = DO;
          rdy_d        = 1'b0;
        end
`endif
      end

      StPend: begin
`ifdef BUS_WAIT_POSTED_WRITE_EN
        // Parked access completes as an ordinary stalling slow access.
        state_d      = StReq;
        mem_req_d    = 1'b1;
        mem_we_d     = pend_we_q;
        mem_addr_d   = pend_addr_q;
        mem_wdata_d  = pend_wdata_q;
        pend_valid_d = 1'b0;
        rdy_d        = 1'b0;
`else
        state_d = StIdle;
        rdy_d   = 1'b1;
`endif
      end

      default: begin
        state_d   = StIdle;
        rdy_d     = 1'b1;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= DiSlow;
      rdy_q       <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      slow_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rdy_q       <= rdy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      slow_q      <= slow_d;
    end
  end

`ifdef BUS_WAIT_POSTED_WRITE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= 16'h0000;
      pend_wdata_q <= 8'h00;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end
`endif

  // Reset selects the slow register, which resets to 0, so DI resets to 0
  // without resetting the RAM output register.
  assign DI        = (sel_q == DiRam) ? ram_rdata : slow_q;
  assign RDY       = rdy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bus_wait.sv
// Directed self-checking bench for bus_wait. Expected read data is pushed to a
// scoreboard queue when a read is presented and popped when DI must be valid.
module tb_bus_wait;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  bus_wait dut (
    .clk       (clk),
    .reset     (reset),
    .AB        (AB),
    .DO        (DO),
    .WE        (WE),
    .DI        (DI),
    .RDY       (RDY),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // Harmless filler access: fast write to a scratch location.
  task automatic idle();
    AB = 16'h01F0;
    WE = 1'b1;
    DO = 8'h00;
  endtask

  task automatic fast_write(input logic [15:0] a, input logic [7:0] d);
    AB = a; WE = 1'b1; DO = d;
    chk("fast_wr_rdy", RDY, 1'b1);
    step();
    idle();
    chk("fast_wr_rdy_after", RDY, 1'b1);
  endtask

  task automatic fast_read(input logic [15:0] a, input logic [7:0] d);
    AB = a; WE = 1'b0; DO = 8'h00;
    chk("fast_rd_rdy", RDY, 1'b1);
    exp_q.push_back(d);
    step();
    idle();
    chk("fast_rd_no_stall", RDY, 1'b1);
    chk("fast_rd_di", DI, pop_exp());
  endtask

  // Starts in the accepting cycle; returns in the cycle after the ack.
  task automatic slow_read(input logic [15:0] a, input logic [7:0] d, input int delay);
    int stall;
    chk("slow_rd_req_gap", mem_req, 1'b0);
    AB = a; WE = 1'b0; DO = 8'h00;
    chk("slow_rd_rdy_accept", RDY, 1'b1);
    exp_q.push_back(d);
    step();
    idle();
    chk("slow_rd_req", mem_req, 1'b1);
    chk("slow_rd_addr", mem_addr, a);
    chk("slow_rd_we", mem_we, 1'b0);
    stall = (RDY == 1'b0) ? 1 : 0;
    for (int i = 0; i < delay; i++) begin
      step();
      if (RDY == 1'b0) stall++;
    end
    mem_ack = 1'b1;
    mem_rdata = d;
    step();
    mem_ack = 1'b0;
    mem_rdata = 8'hE7;
    chk("slow_rd_stall_len", stall, delay + 1);
    chk("slow_rd_rdy_done", RDY, 1'b1);
    chk("slow_rd_req_drop", mem_req, 1'b0);
    chk("slow_rd_di", DI, pop_exp());
  endtask

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    idle();
    step();
    step();
    reset = 1'b0;

    chk("rst_rdy", RDY, 1'b1);
    chk("rst_di", DI, 8'h00);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 8'h00);

    fast_write(16'h0042, 8'hA5);
    fast_read(16'h0042, 8'hA5);

    slow_read(16'h8000, 8'h3C, 3);

    fast_write(16'h01FF, 8'h5A);
    fast_read(16'h01FF, 8'h5A);
    slow_read(16'h0200, 8'hC3, 1);

    slow_read(16'h8100, 8'h21, 0);
    slow_read(16'h8101, 8'h22, 0);

`ifdef BUS_WAIT_POSTED_WRITE_EN
    AB = 16'h9000; WE = 1'b1; DO = 8'h11;
    chk("pw_wr_accept", RDY, 1'b1);
    step();
    chk("pw_wr_no_stall", RDY, 1'b1);
    chk("pw_wr_req", mem_req, 1'b1);
    chk("pw_wr_addr", mem_addr, 16'h9000);
    chk("pw_wr_we", mem_we, 1'b1);
    chk("pw_wr_wdata", mem_wdata, 8'h11);
    AB = 16'h9001; WE = 1'b0; DO = 8'h00;
    exp_q.push_back(8'h77);
    step();
    idle();
    chk("pw_rd_stall", RDY, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0;
    chk("pw_gap_req", mem_req, 1'b0);
    chk("pw_gap_rdy", RDY, 1'b0);
    step();
    chk("pw_rd_req", mem_req, 1'b1);
    chk("pw_rd_addr", mem_addr, 16'h9001);
    chk("pw_rd_we", mem_we, 1'b0);
    chk("pw_rd_still_stall", RDY, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    chk("pw_rd_rdy", RDY, 1'b1);
    chk("pw_rd_req_drop", mem_req, 1'b0);
    chk("pw_rd_di", DI, pop_exp());
`else
    // Slow write above the RAM window must stall, not alias into RAM, and leave DI alone.
    AB = 16'h0242; WE = 1'b1; DO = 8'hFF;
    chk("sw_accept", RDY, 1'b1);
    step();
    idle();
    chk("sw_stall", RDY, 1'b0);
    chk("sw_req", mem_req, 1'b1);
    chk("sw_we", mem_we, 1'b1);
    chk("sw_addr", mem_addr, 16'h0242);
    chk("sw_wdata", mem_wdata, 8'hFF);
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    chk("sw_rdy_done", RDY, 1'b1);
    chk("sw_req_drop", mem_req, 1'b0);
    chk("sw_di_hold", DI, 8'h22);
    fast_read(16'h0042, 8'hA5);
`endif

    // Reset while a slow read is outstanding; a late ack must be ignored.
    AB = 16'h8000; WE = 1'b0; DO = 8'h00;
    chk("rr_accept", RDY, 1'b1);
    step();
    idle();
    chk("rr_req", mem_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_req_cleared", mem_req, 1'b0);
    chk("rr_rdy", RDY, 1'b1);
    chk("rr_di_reset", DI, 8'h00);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0;
    chk("rr_stray_di", DI, 8'h00);
    chk("rr_stray_rdy", RDY, 1'b1);
    chk("rr_stray_req", mem_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
